// File: rtl/control_unit.sv
// Hardwired control sequencer for the multicycle CPU: fetch in T0-T2, execute
// in T3-T7, with Moore strobes decoded from the registered state and ir.
`timescale 1ns/1ps
module control_unit (
  input  logic       clk,
  input  logic       clr,
  input  logic [31:0] ir,
  input  logic       con_ff,
  input  logic       stop,
  output logic       PCout,
  output logic       ZLowout,
  output logic       MDRout,
  output logic       Cout,
  output logic       PCin,
  output logic       IRin,
  output logic       Yin,
  output logic       ZLOin,
  output logic       MARin,
  output logic       MDRin,
  output logic       CONin,
  output logic       GRA,
  output logic       GRB,
  output logic       GRC,
  output logic       R_in,
  output logic       R_out,
  output logic       Baout,
  output logic       Read,
  output logic       IncPC,
  output logic       RAM_wr_enable,
  output logic       run,
  output logic [4:0] operation
);

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  typedef struct packed {
    logic       pc_out;
    logic       zlow_out;
    logic       mdr_out;
    logic       c_out;
    logic       pc_in;
    logic       ir_in;
    logic       y_in;
    logic       zlo_in;
    logic       mar_in;
    logic       mdr_in;
    logic       con_in;
    logic       gra;
    logic       grb;
    logic       grc;
    logic       r_in;
    logic       r_out;
    logic       ba_out;
    logic       read;
    logic       inc_pc;
    logic       ram_wr;
    logic       run;
    logic [4:0] operation;
  } ctl_t;

  state_t     state, state_nxt;
  ctl_t       c;
  logic [4:0] op;
  logic       is_alu, is_addi, is_ld, is_st, is_br, is_halt;
  logic       unused_ir;

  assign op        = ir[31:27];
  assign unused_ir = ^ir[26:0];
  assign is_alu    = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
  assign is_addi   = (op == OP_ADDI);
  assign is_ld     = (op == OP_LD);
  assign is_st     = (op == OP_ST);
  assign is_br     = (op == OP_BR);
  assign is_halt   = (op == OP_HALT);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= S_RESET;
    else     state <= state_nxt;
  end

  // stop is only sampled on an instruction's final edge, so raising it
  // mid-instruction never disturbs the remaining strobes.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_RESET: state_nxt = S_T0;
      S_T0:    state_nxt = S_T1;
      S_T1:    state_nxt = S_T2;
      S_T2:    state_nxt = S_T3;
      S_T3: begin
        if (is_alu || is_addi || is_ld || is_st || is_br) state_nxt = S_T4;
        else if (is_halt)                                 state_nxt = S_HALT;
        else                                              state_nxt = stop ? S_HALT : S_T0;
      end
      S_T4:    state_nxt = S_T5;
      S_T5: begin
        if (is_ld || is_st || is_br) state_nxt = S_T6;
        else                         state_nxt = stop ? S_HALT : S_T0;
      end
      S_T6: begin
        if (is_ld || is_st) state_nxt = S_T7;
        else                state_nxt = stop ? S_HALT : S_T0;
      end
      S_T7:    state_nxt = stop ? S_HALT : S_T0;
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_RESET;
    endcase
  end

  always_comb begin
    c     = '0;
    c.run = (state != S_RESET) && (state != S_HALT);
    unique case (state)
      S_T0: begin
        c.pc_out    = 1'b1;
        c.mar_in    = 1'b1;
        c.inc_pc    = 1'b1;
        c.zlo_in    = 1'b1;
        c.operation = OP_ADD;
      end
      S_T1: begin
        c.zlow_out = 1'b1;
        c.pc_in    = 1'b1;
        c.read     = 1'b1;
        c.mdr_in   = 1'b1;
      end
      S_T2: begin
        c.mdr_out = 1'b1;
        c.ir_in   = 1'b1;
      end
      S_T3: begin
        if (is_alu || is_addi || is_ld || is_st) begin
          c.grb    = 1'b1;
          c.r_out  = 1'b1;
          c.y_in   = 1'b1;
          c.ba_out = is_ld || is_st;
        end else if (is_br) begin
          c.gra    = 1'b1;
          c.r_out  = 1'b1;
          c.con_in = 1'b1;
        end
      end
      S_T4: begin
        if (is_alu) begin
          c.grc       = 1'b1;
          c.r_out     = 1'b1;
          c.zlo_in    = 1'b1;
          c.operation = op;
        end else if (is_addi || is_ld || is_st) begin
          c.c_out     = 1'b1;
          c.zlo_in    = 1'b1;
          c.operation = OP_ADD;
        end else if (is_br) begin
          c.pc_out = 1'b1;
          c.y_in   = 1'b1;
        end
      end
      S_T5: begin
        if (is_alu || is_addi) begin
          c.zlow_out = 1'b1;
          c.gra      = 1'b1;
          c.r_in     = 1'b1;
        end else if (is_ld || is_st) begin
          c.zlow_out = 1'b1;
          c.mar_in   = 1'b1;
        end else if (is_br) begin
          c.c_out     = 1'b1;
          c.zlo_in    = 1'b1;
          c.operation = OP_ADD;
        end
      end
      S_T6: begin
        if (is_ld) begin
          c.read   = 1'b1;
          c.mdr_in = 1'b1;
        end else if (is_st) begin
          c.gra    = 1'b1;
          c.r_out  = 1'b1;
          c.mdr_in = 1'b1;
        end else if (is_br && con_ff) begin
          c.zlow_out = 1'b1;
          c.pc_in    = 1'b1;
        end
      end
      S_T7: begin
        if (is_ld) begin
          c.mdr_out = 1'b1;
          c.gra     = 1'b1;
          c.r_in    = 1'b1;
        end else if (is_st) begin
          c.ram_wr = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign PCout         = c.pc_out;
  assign ZLowout       = c.zlow_out;
  assign MDRout        = c.mdr_out;
  assign Cout          = c.c_out;
  assign PCin          = c.pc_in;
  assign IRin          = c.ir_in;
  assign Yin           = c.y_in;
  assign ZLOin         = c.zlo_in;
  assign MARin         = c.mar_in;
  assign MDRin         = c.mdr_in;
  assign CONin         = c.con_in;
  assign GRA           = c.gra;
  assign GRB           = c.grb;
  assign GRC           = c.grc;
  assign R_in          = c.r_in;
  assign R_out         = c.r_out;
  assign Baout         = c.ba_out;
  assign Read          = c.read;
  assign IncPC         = c.inc_pc;
  assign RAM_wr_enable = c.ram_wr;
  assign run           = c.run;
  assign operation     = c.operation;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: per-instruction strobe sequences, halt,
// stop handling and asynchronous clear.
`timescale 1ns/1ps
module tb_control_unit;
  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] ir;
  logic        con_ff;
  logic        stop;
  logic PCout, ZLowout, MDRout, Cout, PCin, IRin, Yin, ZLOin, MARin, MDRin, CONin;
  logic GRA, GRB, GRC, R_in, R_out, Baout, Read, IncPC, RAM_wr_enable, run;
  logic [4:0] operation;

  control_unit dut (
    .clk(clk), .clr(clr), .ir(ir), .con_ff(con_ff), .stop(stop),
    .PCout(PCout), .ZLowout(ZLowout), .MDRout(MDRout), .Cout(Cout),
    .PCin(PCin), .IRin(IRin), .Yin(Yin), .ZLOin(ZLOin), .MARin(MARin),
    .MDRin(MDRin), .CONin(CONin), .GRA(GRA), .GRB(GRB), .GRC(GRC),
    .R_in(R_in), .R_out(R_out), .Baout(Baout), .Read(Read), .IncPC(IncPC),
    .RAM_wr_enable(RAM_wr_enable), .run(run), .operation(operation)
  );

  always #5 clk = ~clk;

  logic [25:0] obs;
  assign obs = {PCout, ZLowout, MDRout, Cout, PCin, IRin, Yin, ZLOin, MARin, MDRin,
                CONin, GRA, GRB, GRC, R_in, R_out, Baout, Read, IncPC, RAM_wr_enable,
                run, operation};

  localparam logic [25:0] PCOUT   = 26'd1 << 25;
  localparam logic [25:0] ZLOWOUT = 26'd1 << 24;
  localparam logic [25:0] MDROUT  = 26'd1 << 23;
  localparam logic [25:0] COUT    = 26'd1 << 22;
  localparam logic [25:0] PCIN    = 26'd1 << 21;
  localparam logic [25:0] IRIN    = 26'd1 << 20;
  localparam logic [25:0] YIN     = 26'd1 << 19;
  localparam logic [25:0] ZLOIN   = 26'd1 << 18;
  localparam logic [25:0] MARIN   = 26'd1 << 17;
  localparam logic [25:0] MDRIN   = 26'd1 << 16;
  localparam logic [25:0] CONIN   = 26'd1 << 15;
  localparam logic [25:0] GRA_B   = 26'd1 << 14;
  localparam logic [25:0] GRB_B   = 26'd1 << 13;
  localparam logic [25:0] GRC_B   = 26'd1 << 12;
  localparam logic [25:0] RIN     = 26'd1 << 11;
  localparam logic [25:0] ROUT    = 26'd1 << 10;
  localparam logic [25:0] BAOUT   = 26'd1 << 9;
  localparam logic [25:0] READ    = 26'd1 << 8;
  localparam logic [25:0] INCPC   = 26'd1 << 7;
  localparam logic [25:0] RAMWR   = 26'd1 << 6;
  localparam logic [25:0] RUN     = 26'd1 << 5;

  localparam logic [25:0] E_T0 = PCOUT | MARIN | INCPC | ZLOIN | RUN | 26'd3;
  localparam logic [25:0] E_T1 = ZLOWOUT | PCIN | READ | MDRIN | RUN;
  localparam logic [25:0] E_T2 = MDROUT | IRIN | RUN;

  int checks   = 0;
  int failures = 0;

  // Hold clr over a falling edge, then release; the next rising edge enters T0.
  task automatic start(input logic [31:0] instr, input logic cf, input logic stp);
    ir     = instr;
    con_ff = cf;
    stop   = stp;
    clr    = 1'b1;
    @(negedge clk);
    clr    = 1'b0;
  endtask

  task automatic test_reset;
    clr = 1'b1; ir = 32'h1800_0000; con_ff = 1'b0; stop = 1'b0;
    #1;
    if (obs !== 26'd0) begin $display("FAIL reset_async got=%h want=%h", obs, 26'd0); failures++; end
    checks++;
    @(posedge clk); #1;
    if (obs !== 26'd0) begin $display("FAIL reset_held got=%h want=%h", obs, 26'd0); failures++; end
    checks++;
    @(negedge clk); clr = 1'b0;
    @(negedge clk);
    if (obs !== E_T0) begin $display("FAIL reset_to_t0 got=%h want=%h", obs, E_T0); failures++; end
    checks++;
  endtask

  task automatic test_alu(input logic [31:0] instr, input logic [4:0] op, input string nm);
    logic [25:0] exp_q[$];
    exp_q = '{E_T0, E_T1, E_T2, GRB_B | ROUT | YIN | RUN,
              GRC_B | ROUT | ZLOIN | RUN | 26'(op), ZLOWOUT | GRA_B | RIN | RUN, E_T0};
    start(instr, 1'b0, 1'b0);
    foreach (exp_q[i]) begin
      @(negedge clk);
      if (obs !== exp_q[i]) begin $display("FAIL %s step%0d got=%h want=%h", nm, i, obs, exp_q[i]); failures++; end
      checks++;
    end
  endtask

  task automatic test_addi;
    logic [25:0] exp_q[$];
    exp_q = '{E_T0, E_T1, E_T2, GRB_B | ROUT | YIN | RUN, COUT | ZLOIN | RUN | 26'd3,
              ZLOWOUT | GRA_B | RIN | RUN, E_T0};
    start(32'h6000_0000, 1'b0, 1'b0);
    foreach (exp_q[i]) begin
      @(negedge clk);
      if (obs !== exp_q[i]) begin $display("FAIL addi step%0d got=%h want=%h", i, obs, exp_q[i]); failures++; end
      checks++;
    end
  endtask

  task automatic test_ld_st(input logic is_st);
    logic [25:0] exp_q[$];
    exp_q = '{E_T0, E_T1, E_T2, GRB_B | ROUT | BAOUT | YIN | RUN, COUT | ZLOIN | RUN | 26'd3,
              ZLOWOUT | MARIN | RUN,
              is_st ? (GRA_B | ROUT | MDRIN | RUN) : (READ | MDRIN | RUN),
              is_st ? (RAMWR | RUN) : (MDROUT | GRA_B | RIN | RUN), E_T0};
    start(is_st ? 32'h1000_0000 : 32'h0000_0000, 1'b0, 1'b0);
    foreach (exp_q[i]) begin
      @(negedge clk);
      if (obs !== exp_q[i]) begin
        $display("FAIL %s step%0d got=%h want=%h", is_st ? "st" : "ld", i, obs, exp_q[i]);
        failures++;
      end
      checks++;
    end
  endtask

  task automatic test_br(input logic cf);
    logic [25:0] exp_q[$];
    exp_q = '{E_T0, E_T1, E_T2, GRA_B | ROUT | CONIN | RUN, PCOUT | YIN | RUN,
              COUT | ZLOIN | RUN | 26'd3, cf ? (ZLOWOUT | PCIN | RUN) : RUN, E_T0};
    start(32'h9000_0000, cf, 1'b0);
    foreach (exp_q[i]) begin
      @(negedge clk);
      if (obs !== exp_q[i]) begin $display("FAIL br_cf%0d step%0d got=%h want=%h", cf, i, obs, exp_q[i]); failures++; end
      checks++;
    end
  endtask

  task automatic test_nop(input logic [31:0] instr, input string nm);
    logic [25:0] exp_q[$];
    exp_q = '{E_T0, E_T1, E_T2, RUN, E_T0, E_T1};
    start(instr, 1'b0, 1'b0);
    foreach (exp_q[i]) begin
      @(negedge clk);
      if (obs !== exp_q[i]) begin $display("FAIL %s step%0d got=%h want=%h", nm, i, obs, exp_q[i]); failures++; end
      checks++;
    end
  endtask

  task automatic test_halt;
    logic [25:0] exp_q[$];
    exp_q = '{E_T0, E_T1, E_T2, RUN};
    start(32'hD800_0000, 1'b0, 1'b0);
    foreach (exp_q[i]) begin
      @(negedge clk);
      if (obs !== exp_q[i]) begin $display("FAIL halt step%0d got=%h want=%h", i, obs, exp_q[i]); failures++; end
      checks++;
    end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (obs !== 26'd0) begin $display("FAIL halt_hold cyc%0d got=%h want=%h", k, obs, 26'd0); failures++; end
      checks++;
    end
    clr = 1'b1; #1;
    if (obs !== 26'd0) begin $display("FAIL halt_clr got=%h want=%h", obs, 26'd0); failures++; end
    checks++;
    @(negedge clk); clr = 1'b0;
    @(negedge clk);
    if (obs !== E_T0) begin $display("FAIL halt_restart got=%h want=%h", obs, E_T0); failures++; end
    checks++;
  endtask

  task automatic test_clr_mid;
    logic [25:0] t4;
    t4 = GRC_B | ROUT | ZLOIN | RUN | 26'd3;
    start(32'h1800_0000, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    if (obs !== t4) begin $display("FAIL clr_mid_t4 got=%h want=%h", obs, t4); failures++; end
    checks++;
    clr = 1'b1; #1;
    if (obs !== 26'd0) begin $display("FAIL clr_mid_async got=%h want=%h", obs, 26'd0); failures++; end
    checks++;
    @(negedge clk);
    if (obs !== 26'd0) begin $display("FAIL clr_mid_held got=%h want=%h", obs, 26'd0); failures++; end
    checks++;
    clr = 1'b0;
    @(negedge clk);
    if (obs !== E_T0) begin $display("FAIL clr_mid_t0 got=%h want=%h", obs, E_T0); failures++; end
    checks++;
    @(negedge clk);
    if (obs !== E_T1) begin $display("FAIL clr_mid_t1 got=%h want=%h", obs, E_T1); failures++; end
    checks++;
  endtask

  task automatic test_stop_sub;
    logic [25:0] exp_q[$];
    exp_q = '{E_T0, E_T1, E_T2, GRB_B | ROUT | YIN | RUN, GRC_B | ROUT | ZLOIN | RUN | 26'd4,
              ZLOWOUT | GRA_B | RIN | RUN, 26'd0, 26'd0};
    start(32'h2000_0000, 1'b0, 1'b0);
    foreach (exp_q[i]) begin
      @(negedge clk);
      if (obs !== exp_q[i]) begin $display("FAIL stop_sub step%0d got=%h want=%h", i, obs, exp_q[i]); failures++; end
      checks++;
      if (i == 2) stop = 1'b1;
    end
    stop = 1'b0;
    repeat (2) @(negedge clk);
    if (obs !== 26'd0) begin $display("FAIL stop_sub_stays got=%h want=%h", obs, 26'd0); failures++; end
    checks++;
  endtask

  task automatic test_stop_nop;
    logic [25:0] exp_q[$];
    exp_q = '{E_T0, E_T1, E_T2, RUN, 26'd0};
    start(32'hD000_0000, 1'b0, 1'b1);
    foreach (exp_q[i]) begin
      @(negedge clk);
      if (obs !== exp_q[i]) begin $display("FAIL stop_nop step%0d got=%h want=%h", i, obs, exp_q[i]); failures++; end
      checks++;
    end
    stop = 1'b0;
  endtask

  initial begin
    test_reset();
    test_alu(32'h1800_0000, 5'b00011, "add");
    test_alu(32'h2000_0000, 5'b00100, "sub");
    test_alu(32'h2800_0000, 5'b00101, "and");
    test_alu(32'h3000_0000, 5'b00110, "or");
    test_addi();
    test_ld_st(1'b0);
    test_ld_st(1'b1);
    test_br(1'b1);
    test_br(1'b0);
    test_nop(32'hD000_0000, "nop");
    test_nop(32'h0800_0000, "unknown");
    test_halt();
    test_clr_mid();
    test_stop_sub();
    test_stop_nop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
